// File: rtl/fifo_wr_arbiter_if.sv
// fifo_wr_arbiter_if: requester/FIFO-side bundle of the shared write-port arbiter
interface fifo_wr_arbiter_if #(
    parameter int NREQ      = 4,
    parameter int DSIZE     = 8,
    parameter int MAX_BURST = 4
);
    logic [NREQ-1:0]            req_valid;
    logic [NREQ*DSIZE-1:0]      req_data;
    logic [NREQ-1:0]            req_last;
    logic [NREQ-1:0]            req_ready;
    logic                       wfull;
    logic                       winc;
    logic [DSIZE-1:0]           wdata;
    logic                       gnt_valid;
    logic [$clog2(NREQ)-1:0]    gnt_id;
    logic [$clog2(MAX_BURST):0] beat_cnt;
    modport master (
        output req_valid, req_data, req_last, wfull,
        input  req_ready, winc, wdata, gnt_valid, gnt_id, beat_cnt
    );
    modport slave (
        input  req_valid, req_data, req_last, wfull,
        output req_ready, winc, wdata, gnt_valid, gnt_id, beat_cnt
    );
endinterface

// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: round-robin burst arbiter sharing one FIFO write port among NREQ requesters
module fifo_wr_arbiter #(
    parameter int NREQ      = 4,
    parameter int DSIZE     = 8,
    parameter int MAX_BURST = 4
) (
    input logic              wclk,
    input logic              wrst,
    fifo_wr_arbiter_if.slave bus
);
    localparam int GW = $clog2(NREQ);
    localparam int BW = $clog2(MAX_BURST) + 1;
    typedef enum logic {IDLE, BURST} state_e;
    state_e          state_q, state_d;
    logic [GW-1:0]   gnt_q, gnt_d, last_q, last_d, sel, idx;
    logic [BW-1:0]   beat_q, beat_d;
    logic            found, active, out_en, cur_valid, cur_last, xfer;
    always_comb begin
        sel   = '0;
        idx   = '0;
        found = 1'b0;
        for (int i = 1; i <= NREQ; i++) begin
            idx = GW'((int'(last_q) + i) % NREQ);
            if (!found && bus.req_valid[idx]) begin
                sel   = idx;
                found = 1'b1;
            end
        end
    end
    assign active    = (state_q == BURST);
    // outputs are forced quiet while reset is held, even before the edge lands
    assign out_en    = active && !wrst;
    assign cur_valid = bus.req_valid[gnt_q];
    assign cur_last  = bus.req_last[gnt_q];
    assign xfer      = active && cur_valid && !bus.wfull;
    assign bus.gnt_valid = out_en;
    assign bus.gnt_id    = gnt_q;
    assign bus.beat_cnt  = beat_q;
    assign bus.req_ready = (out_en && !bus.wfull) ? NREQ'(1) << gnt_q : '0;
    assign bus.winc      = xfer && !wrst;
    assign bus.wdata     = out_en ? bus.req_data[gnt_q*DSIZE +: DSIZE] : '0;
    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        last_d  = last_q;
        beat_d  = beat_q;
        if (state_q == IDLE) begin
            if (found) begin
                state_d = BURST;
                gnt_d   = sel;
                last_d  = sel;
                beat_d  = '0;
            end
        end else if (xfer) begin
            beat_d = beat_q + 1'b1;
            if (cur_last || beat_q == BW'(MAX_BURST - 1)) state_d = IDLE;
        end else if (!cur_valid && !bus.wfull) begin
            state_d = IDLE;
        end
    end
    always_ff @(posedge wclk) begin
        if (wrst) begin
            state_q <= IDLE;
            gnt_q   <= '0;
            last_q  <= GW'(NREQ - 1);
            beat_q  <= '0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            last_q  <= last_d;
            beat_q  <= beat_d;
        end
    end
endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// tb_fifo_wr_arbiter: scoreboard bench for the round-robin FIFO write arbiter
module tb_fifo_wr_arbiter;
    localparam int NREQ = 4, DSIZE = 8, MAX_BURST = 4;
    typedef struct {logic [1:0] gid; logic [7:0] data;} wr_t;
    logic wclk = 1'b0;
    logic wrst;
    fifo_wr_arbiter_if #(.NREQ(NREQ), .DSIZE(DSIZE), .MAX_BURST(MAX_BURST)) bus();
    fifo_wr_arbiter #(.NREQ(NREQ), .DSIZE(DSIZE), .MAX_BURST(MAX_BURST)) dut (
        .wclk(wclk),
        .wrst(wrst),
        .bus (bus)
    );
    always #5 wclk = ~wclk;
    wr_t        wq[$];
    int         gl[$], wc[$];
    int         n_vec = 0, n_err = 0, nw = 0;
    int         wait_c[NREQ];
    bit         m_burst, prev_gv, pend;
    logic [1:0] m_gnt, m_last;
    logic [2:0] m_beat;
    logic [3:0] pv;
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask
    task automatic drive(input logic [3:0] v, input logic [3:0] l, input logic f);
        bus.req_valid = v;
        bus.req_last  = l;
        bus.wfull     = f;
        bus.req_data  = $urandom;
    endtask
    // reference model: expectations computed from the bench's own state, then state advanced
    task automatic cycle();
        logic       ex_winc, found;
        logic [3:0] ex_rdy;
        logic [7:0] ex_data;
        wr_t        w;
        int         j;
        #1;
        ex_winc = m_burst && !wrst && bus.req_valid[m_gnt] && !bus.wfull;
        ex_rdy  = (m_burst && !wrst && !bus.wfull) ? 4'(1) << m_gnt : 4'h0;
        ex_data = (m_burst && !wrst) ? bus.req_data[m_gnt*8 +: 8] : 8'h0;
        if (ex_winc) wq.push_back('{m_gnt, ex_data});
        chk("gnt_valid", bus.gnt_valid, m_burst && !wrst);
        chk("gnt_id", bus.gnt_id, m_gnt);
        chk("beat_cnt", bus.beat_cnt, m_beat);
        chk("req_ready", bus.req_ready, ex_rdy);
        chk("winc", bus.winc, ex_winc);
        chk("wdata", bus.wdata, ex_data);
        chk("winc_full", bus.winc & bus.wfull, 0);
        chk("winc_idle", bus.winc & !bus.gnt_valid, 0);
        if (bus.winc && wq.size() > 0) begin
            w = wq.pop_front();
            chk("wr_gid", bus.gnt_id, w.gid);
            chk("wr_data", bus.wdata, w.data);
        end
        chk("wq_len", wq.size(), 0);
        if (bus.gnt_valid && !prev_gv) begin
            gl.push_back(int'(bus.gnt_id));
            wc.push_back(0);
        end
        if (bus.winc) begin
            nw++;
            if (wc.size() > 0) wc[wc.size()-1]++;
        end
        prev_gv = bus.gnt_valid;
        if (pend && bus.gnt_valid) begin
            for (int i = 0; i < NREQ; i++) begin
                wait_c[i] = (i == int'(bus.gnt_id)) ? 0 : pv[i] ? wait_c[i] + 1 : 0;
                chk("starve", wait_c[i] < NREQ, 1);
            end
        end
        pend = !bus.gnt_valid && !wrst && (|bus.req_valid);
        pv   = bus.req_valid;
        if (wrst) begin
            m_burst = 0; m_gnt = 0; m_beat = 0; m_last = 2'd3;
            for (int i = 0; i < NREQ; i++) wait_c[i] = 0;
        end else if (!m_burst) begin
            found = 0;
            for (int k = 1; k <= NREQ; k++) begin
                j = (int'(m_last) + k) % NREQ;
                if (!found && bus.req_valid[j]) begin
                    found = 1; m_burst = 1; m_gnt = 2'(j); m_last = 2'(j); m_beat = 0;
                end
            end
        end else if (ex_winc) begin
            m_beat++;
            if (bus.req_last[m_gnt] || m_beat == 3'(MAX_BURST)) m_burst = 0;
        end else if (!bus.req_valid[m_gnt] && !bus.wfull) begin
            m_burst = 0;
        end
        @(posedge wclk);
        @(negedge wclk);
    endtask
    task automatic clr();
        gl.delete();
        wc.delete();
        nw = 0;
    endtask
    initial begin
        wrst = 1'b1;
        drive(4'h0, 4'h0, 1'b0);
        prev_gv = 0; pend = 0; pv = 0;
        for (int i = 0; i < NREQ; i++) wait_c[i] = 0;
        @(posedge wclk);
        @(negedge wclk);
        m_burst = 0; m_gnt = 0; m_beat = 0; m_last = 2'd3;
        drive(4'hf, 4'h0, 1'b0);
        cycle();
        cycle();
        wrst = 1'b0;
        // all requesters streaming: full bursts rotate 0,1,2,3,0
        clr();
        for (int c = 0; c < 25; c++) begin
            drive(4'hf, 4'h0, 1'b0);
            cycle();
        end
        chk("rr_count", gl.size(), 5);
        for (int i = 0; i < 5; i++) chk("rr_order", i < gl.size() ? gl[i] : -1, i % 4);
        for (int i = 0; i < 4; i++) chk("rr_beats", i < wc.size() ? wc[i] : -1, 4);
        // lone requester 2 ends its packet on the second word
        clr();
        for (int c = 0; c < 6; c++) begin
            drive(nw == 2 ? 4'h0 : 4'b0100, (bus.gnt_valid && bus.beat_cnt == 1) ? 4'b0100 : 4'h0, 1'b0);
            cycle();
        end
        chk("last_gid", gl.size() > 0 ? gl[0] : -1, 2);
        chk("last_ngnt", gl.size(), 1);
        chk("last_nw", nw, 2);
        chk("last_beat", bus.beat_cnt, 2);
        chk("last_idle", bus.gnt_valid, 0);
        // requester 1 stalled by wfull for three cycles mid-burst
        clr();
        for (int c = 0; c < 10; c++) begin
            drive(c < 8 ? 4'b0010 : 4'h0, 4'h0, c >= 3 && c <= 5);
            #1;
            if (c >= 3 && c <= 5) begin
                chk("stall_winc", bus.winc, 0);
                chk("stall_rdy", bus.req_ready, 0);
                chk("stall_beat", bus.beat_cnt, 2);
            end
            cycle();
        end
        chk("stall_gid", gl.size() > 0 ? gl[0] : -1, 1);
        chk("stall_words", wc.size() > 0 ? wc[0] : -1, 4);
        // requester 3 abandons after one word, requester 0 is next
        clr();
        for (int c = 0; c < 7; c++) begin
            drive(c < 2 ? 4'b1000 : c < 5 ? 4'b0001 : 4'h0, 4'h0, 1'b0);
            #1;
            if (c == 3) begin
                chk("abandon_idle", bus.gnt_valid, 0);
                chk("abandon_beat", bus.beat_cnt, 1);
            end
            if (c == 4) begin
                chk("abandon_next_v", bus.gnt_valid, 1);
                chk("abandon_next_id", bus.gnt_id, 0);
            end
            cycle();
        end
        chk("abandon_gid", gl.size() > 0 ? gl[0] : -1, 3);
        // reset lands after two words of requester 0's burst
        wrst = 1'b1;
        drive(4'h0, 4'h0, 1'b0);
        cycle();
        wrst = 1'b0;
        clr();
        for (int c = 0; c < 8; c++) begin
            wrst = (c == 3);
            drive(c < 4 ? 4'b0001 : c < 6 ? 4'hf : 4'h0, 4'h0, 1'b0);
            #1;
            if (c == 3) chk("rst_winc", bus.winc, 0);
            if (c == 4) begin
                chk("rst_gv", bus.gnt_valid, 0);
                chk("rst_beat", bus.beat_cnt, 0);
            end
            if (c == 5) begin
                chk("rst_regrant_v", bus.gnt_valid, 1);
                chk("rst_regrant_id", bus.gnt_id, 0);
            end
            cycle();
        end
        chk("rst_words", wc.size() > 0 ? wc[0] : -1, 2);
        wrst = 1'b0;
        // random traffic with occasional resets
        for (int c = 0; c < 10000; c++) begin
            wrst = ($urandom_range(0, 499) == 0);
            drive(4'($urandom), ($urandom_range(0, 5) == 0) ? 4'($urandom) : 4'h0, $urandom_range(0, 3) == 0);
            cycle();
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
